// File: rtl/ttl_deser_sync.sv
// ttl_deser_sync: serial-in / parallel-out deserializer.
// Samples din on each rising edge of cen (detected in the clk domain) and
// assembles WIDTH-bit words, MSB-first (dir=0) or LSB-first (dir=1).
// Finished words go to a holding latch that has a valid/ack handshake and a
// sticky overrun flag.
// Optional feature: define DESER_PARITY_EN to take one trailing parity bit per
// word and report a mismatch on perr (PAR_ODD selects even/odd sense).
module ttl_deser_sync #(
   parameter int WIDTH   = 8,
   parameter bit PAR_ODD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic             frame,
   input  logic             dir,
   input  logic             din,
   input  logic             rd_ack,
   output logic [WIDTH-1:0] dout,
   output logic             dvalid,
   output logic             ovr,
   output logic             busy,
   output logic             perr
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef DESER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sr, sr_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             dir_q, dir_nxt;
   logic             last_cen;
   logic             cen_edge;
   logic             commit;
   logic             accept;
`ifdef DESER_PARITY_EN
   logic             par_bad;
`endif

   assign cen_edge = cen & ~last_cen;
   assign busy     = (state != IDLE);
   // A word is taken into the latch when it is empty or being emptied this clk.
   assign accept   = commit & (~dvalid | rd_ack);

   // Next-state logic: frame restarts a word from any state, otherwise shift.
   always_comb begin
      // NOTE: every signal gets a default first, so no path can infer a latch.
      state_nxt = state;
      sr_nxt    = sr;
      cnt_nxt   = cnt;
      dir_nxt   = dir_q;
      commit    = 1'b0;
`ifdef DESER_PARITY_EN
      par_bad   = 1'b0;
`endif
      if (cen_edge) begin
         if (frame) begin
            // First bit lands at the end it will occupy after WIDTH-1 shifts.
            dir_nxt   = dir;
            sr_nxt    = dir ? {din, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, din};
            cnt_nxt   = CW'(1);
            state_nxt = SHIFT;
         end else begin
            case (state)
               SHIFT: begin
                  sr_nxt = dir_q ? {din, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], din};
                  if (cnt == CW'(WIDTH - 1)) begin
                     cnt_nxt = '0;
`ifdef DESER_PARITY_EN
                     state_nxt = PARITY;
`else
                     state_nxt = IDLE;
                     commit    = 1'b1;
`endif
                  end else begin
                     cnt_nxt = cnt + CW'(1);
                  end
               end
`ifdef DESER_PARITY_EN
               PARITY: begin
                  par_bad   = (din != (^sr ^ PAR_ODD));
                  commit    = 1'b1;
                  state_nxt = IDLE;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   // Assembly state registers; last_cen resets high so a held cen is no edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sr       <= '0;
         cnt      <= '0;
         dir_q    <= 1'b0;
         last_cen <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state    <= state_nxt;
         sr       <= sr_nxt;
         cnt      <= cnt_nxt;
         dir_q    <= dir_nxt;
         last_cen <= cen;
      end
   end

   // Holding latch and handshake: commit wins over rd_ack clearing dvalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout   <= '0;
         dvalid <= 1'b0;
         ovr    <= 1'b0;
      end else begin
         if (accept) begin
            dout   <= sr_nxt;
            dvalid <= 1'b1;
         end else if (rd_ack) begin
            dvalid <= 1'b0;
         end
         if (commit && dvalid && !rd_ack) begin
            ovr <= 1'b1;
         end else if (rd_ack && dvalid) begin
            ovr <= 1'b0;
         end
      end
   end

`ifdef DESER_PARITY_EN
   // Parity flag follows the word held in the latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perr <= 1'b0;
      end else if (accept) begin
         perr <= par_bad;
      end else if (rd_ack && dvalid) begin
         perr <= 1'b0;
      end
   end
`else
   // Parity sense only matters to the parity build; perr is a constant 0 here.
   assign perr = PAR_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_ttl_deser_sync.sv
// Directed testbench for ttl_deser_sync (WIDTH=8). Works in both the default
// build and with DESER_PARITY_EN, where each word carries a trailing parity bit.
module tb_ttl_deser_sync;

`ifdef DESER_PARITY_EN
   localparam bit HAS_PAR = 1'b1;
`else
   localparam bit HAS_PAR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       cen, frame, dir, din, rd_ack;
   logic [7:0] dout;
   logic       dvalid, ovr, busy, perr;

   int n_cmp = 0;
   int n_bad = 0;

   ttl_deser_sync #(.WIDTH(8), .PAR_ODD(1'b0)) dut (
      .clk(clk), .rst(rst), .cen(cen), .frame(frame), .dir(dir), .din(din),
      .rd_ack(rd_ack), .dout(dout), .dvalid(dvalid), .ovr(ovr), .busy(busy),
      .perr(perr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One cen pulse (high one clk, low two clks) carrying frame/din/dir/rd_ack.
   task automatic send_bit(input logic f, input logic d, input logic dr, input logic ack);
      @(negedge clk);
      frame = f; din = d; dir = dr; rd_ack = ack; cen = 1'b1;
      @(negedge clk);
      cen = 1'b0; frame = 1'b0; rd_ack = 1'b0;
      @(negedge clk);
   endtask

   // Send seq[7] first with frame on it; appends even parity (optionally
   // inverted) in the parity build. ack_last pulses rd_ack on the commit edge.
   task automatic send_word(input logic dr, input logic [7:0] seq, input logic ack_last,
                            input logic tchk, input logic flip);
      int n;
      logic b;
      n = HAS_PAR ? 9 : 8;
      for (int k = 0; k < n; k++) begin
         b = (k < 8) ? seq[7-k] : (^seq ^ flip);
         @(negedge clk);
         frame = (k == 0); din = b; dir = dr; cen = 1'b1;
         rd_ack = (k == n-1) && ack_last;
         if (k == n-1 && tchk) check("dvalid_before_edge", dvalid, 0);
         @(negedge clk);
         cen = 1'b0; frame = 1'b0; rd_ack = 1'b0;
         if (k == n-1 && tchk) check("dvalid_1clk_after", dvalid, 1);
         @(negedge clk);
      end
   endtask

   task automatic ack();
      @(negedge clk);
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cen = 1'b1; frame = 1'b1; dir = 1'b0; din = 1'b1; rd_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dout", dout, 0);
      check("rst_dvalid", dvalid, 0);
      check("rst_ovr", ovr, 0);
      check("rst_busy", busy, 0);
      check("rst_perr", perr, 0);

      // cen held high (with frame=1) across reset release: no edge.
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("held_cen_no_edge", busy, 0);
      cen = 1'b0; frame = 1'b0;
      @(negedge clk);
      send_bit(1'b1, 1'b1, 1'b0, 1'b0);
      check("one_bit_busy", busy, 1);
      check("one_bit_cnt", dut.cnt, 1);
      // Remaining bits 0,0,0,0,1,1,0 -> 8'b1000_0110
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      if (HAS_PAR) send_bit(1'b0, 1'b1, 1'b0, 1'b0);
      check("first_word", dout, 8'h86);
      ack();

      // MSB-first A5 with dvalid timing.
      send_word(1'b0, 8'b1010_0101, 1'b0, 1'b1, 1'b0);
      check("msb_a5", dout, 8'hA5);
      check("msb_a5_busy", busy, 0);
      ack();
      @(negedge clk);
      check("ack_clears_dvalid", dvalid, 0);

      // LSB-first.
      send_word(1'b1, 8'b1010_0101, 1'b0, 1'b0, 1'b0);
      check("lsb_a5", dout, 8'hA5);
      ack();
      send_word(1'b1, 8'b1100_0000, 1'b0, 1'b0, 1'b0);
      check("lsb_03", dout, 8'h03);
      ack();

      // Overrun.
      send_word(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      send_word(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
      check("ovr_dout_kept", dout, 8'h3C);
      check("ovr_set", ovr, 1);
      check("ovr_dvalid", dvalid, 1);
      ack();
      @(negedge clk);
      check("ovr_ack_dvalid", dvalid, 0);
      check("ovr_ack_clear", ovr, 0);

      // Resync after 4 bits.
      send_bit(1'b1, 1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0, 1'b0);
      send_word(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
      check("resync_81", dout, 8'h81);
      check("resync_busy", busy, 0);

      // Commit with rd_ack in the same clk: accepted, no overrun.
      send_word(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
      check("ack_commit_dout", dout, 8'h5A);
      check("ack_commit_dvalid", dvalid, 1);
      check("ack_commit_ovr", ovr, 0);
      ack();

      // rd_ack while empty does nothing.
      ack();
      @(negedge clk);
      check("idle_ack_dvalid", dvalid, 0);
      check("idle_ack_dout", dout, 8'h5A);

`ifdef DESER_PARITY_EN
      send_word(1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
      check("par_ok_perr", perr, 0);
      ack();
      send_word(1'b0, 8'h07, 1'b0, 1'b0, 1'b1);
      check("par_bad_perr", perr, 1);
      check("par_bad_dout", dout, 8'h07);
      ack();
      @(negedge clk);
      check("par_ack_clear", perr, 0);
`endif

      // Asynchronous reset mid-word with a full latch.
      send_word(1'b0, 8'hE7, 1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_dvalid", dvalid, 0);
      check("midrst_dout", dout, 0);
      check("midrst_cnt", dut.cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
